// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester handshake and serial-line bundle for uart_tx_sched
interface uart_tx_sched_if #(parameter int NumReq = 2);
  logic [NumReq-1:0] req_valid_i;
  logic [NumReq*8-1:0] req_data_i;
  logic [NumReq-1:0] req_ready_o;
  logic [NumReq-1:0] grant_o;
  logic tx_o;
  logic busy_o;
  modport master (output req_valid_i, req_data_i, input req_ready_o, grant_o, tx_o, busy_o);
  modport slave (input req_valid_i, req_data_i, output req_ready_o, grant_o, tx_o, busy_o);
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin, line-locked scheduler serialising requester bytes onto one 8N1 line
module uart_tx_sched #(
  parameter int NumReq = 2,
  parameter int ClockFrequency = 33_000_000,
  parameter int BaudRate = 115_200,
  parameter int MaxBurst = 64
) (
  input logic clk_i,
  input logic rst_ni,
  uart_tx_sched_if.slave bus
);
  localparam int Div = ClockFrequency / BaudRate;
  localparam int CW = $clog2(Div);
  localparam int BW = $clog2(MaxBurst + 1);
  localparam int LW = NumReq > 1 ? $clog2(NumReq) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d, byte_in;
  logic [LW-1:0] last_q, last_d, sel, cand;
  logic [BW-1:0] burst_q, burst_d;
  logic [NumReq-1:0] grant_q, grant_d, sel_oh;
  logic lock_q, lock_d, tx_q, tx_d, acc, bit_end;
  always_comb begin
    sel = last_q;
    cand = last_q;
    for (int o = NumReq; o >= 1; o--) begin
      cand = LW'((int'(last_q) + o) % NumReq);
      if (bus.req_valid_i[cand]) sel = cand;
    end
    if (lock_q && bus.req_valid_i[last_q]) sel = last_q;
  end
  assign sel_oh = NumReq'(1) << sel;
  assign byte_in = bus.req_data_i[8*sel +: 8];
  assign acc = rst_ni && state_q == IDLE && |bus.req_valid_i;
  assign bit_end = cnt_q == CW'(Div - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    sh_d = sh_q;
    last_d = last_q;
    burst_d = burst_q;
    grant_d = grant_q;
    lock_d = lock_q;
    tx_d = tx_q;
    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    if (acc) begin
      state_d = START;
      cnt_d = '0;
      idx_d = '0;
      sh_d = byte_in;
      last_d = sel;
      grant_d = sel_oh;
      burst_d = (lock_q && sel == last_q) ? (burst_q == BW'(MaxBurst) ? burst_q : burst_q + 1'b1) : BW'(1);
      lock_d = byte_in != 8'h0A && burst_d < BW'(MaxBurst);
      tx_d = 1'b0;
    end else if (state_q == IDLE) begin
      grant_d = '0;
      lock_d = 1'b0;
    end else if (bit_end) begin
      if (state_q == START) begin
        state_d = DATA;
        tx_d = sh_q[0];
      end else if (state_q == STOP) begin
        state_d = IDLE;
      end else if (idx_q == 3'd7) begin
        state_d = STOP;
        tx_d = 1'b1;
      end else begin
        idx_d = idx_q + 3'd1;
        tx_d = sh_q[1];
        sh_d = sh_q >> 1;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      last_q <= LW'(NumReq - 1);
      burst_q <= '0;
      grant_q <= '0;
      lock_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      last_q <= last_d;
      burst_q <= burst_d;
      grant_q <= grant_d;
      lock_q <= lock_d;
      tx_q <= tx_d;
    end
  end
  // grant follows arbitration combinationally while idle so a release is visible immediately
  assign bus.grant_o = !rst_ni ? '0 : (state_q == IDLE ? grant_d : grant_q);
  assign bus.req_ready_o = acc ? sel_oh : '0;
  assign bus.tx_o = tx_q;
  assign bus.busy_o = state_q != IDLE;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed and random scenarios checked against a transaction-level arbitration model
module tb_uart_tx_sched;
  localparam int NumReq = 2;
  localparam int MaxBurst = 4;
  typedef struct {int r; logic [7:0] b;} ev_t;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int m_last = NumReq - 1;
  int m_burst = 0;
  bit m_lock = 1'b0;
  logic [7:0] q [NumReq][$];
  ev_t exp_q[$];
  always #5 clk = ~clk;
  uart_tx_sched_if #(.NumReq(NumReq)) bus ();
  uart_tx_sched #(.NumReq(NumReq), .ClockFrequency(8), .BaudRate(1), .MaxBurst(MaxBurst)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus));
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < NumReq; i++) begin
      bus.req_valid_i[i] = q[i].size() > 0;
      bus.req_data_i[i*8 +: 8] = q[i].size() > 0 ? q[i][0] : 8'h00;
    end
  endtask
  function automatic logic exp_tx(logic [7:0] b, int d);
    int j = (d - 1) / 8;
    return j == 0 ? 1'b0 : j == 9 ? 1'b1 : b[j-1];
  endfunction
  // predicts the accept order from the queued bytes: line lock, burst cap, round-robin
  task automatic model();
    logic [7:0] mq [NumReq][$];
    int s;
    ev_t ev;
    int left;
    exp_q.delete();
    left = 0;
    for (int i = 0; i < NumReq; i++) begin
      foreach (q[i][j]) mq[i].push_back(q[i][j]);
      left += q[i].size();
    end
    m_lock = 1'b0;
    while (left > 0) begin
      s = -1;
      if (m_lock && mq[m_last].size() > 0) s = m_last;
      for (int o = 1; o <= NumReq; o++)
        if (s < 0 && mq[(m_last + o) % NumReq].size() > 0) s = (m_last + o) % NumReq;
      m_burst = (m_lock && s == m_last) ? (m_burst < MaxBurst ? m_burst + 1 : MaxBurst) : 1;
      ev.r = s;
      ev.b = mq[s].pop_front();
      m_lock = ev.b != 8'h0A && m_burst < MaxBurst;
      m_last = s;
      exp_q.push_back(ev);
      left--;
    end
  endtask
  task automatic run(string nm);
    int t_acc, k, fr, d, r;
    logic [7:0] fb;
    logic acc;
    model();
    t_acc = -1000;
    k = 0;
    fr = 0;
    fb = 8'h00;
    for (int c = 0; c < 82 * exp_q.size() + 20; c++) begin
      drive();
      @(negedge clk);
      d = c - t_acc;
      if (d >= 1 && d <= 80) begin
        chk({nm, " tx"}, 32'(bus.tx_o), 32'(exp_tx(fb, d)));
        chk({nm, " busy"}, 32'(bus.busy_o), 32'd1);
        if (d == 40) begin
          chk({nm, " grant mid"}, 32'(bus.grant_o), 32'(1 << fr));
          chk({nm, " ready mid"}, 32'(bus.req_ready_o), 32'd0);
        end
      end
      if (d == 81) chk({nm, " busy end"}, 32'(bus.busy_o), 32'd0);
      acc = |(bus.req_valid_i & bus.req_ready_o);
      if (acc) begin
        r = bus.req_ready_o[1] ? 1 : 0;
        chk({nm, " ready onehot"}, 32'($countones(bus.req_ready_o)), 32'd1);
        if (k < exp_q.size()) begin
          chk($sformatf("%s req#%0d", nm, k), 32'(r), 32'(exp_q[k].r));
          fb = exp_q[k].b;
        end else chk({nm, " extra accept"}, 32'(k), 32'(exp_q.size()));
        if (k > 0) chk({nm, " spacing"}, 32'(d), 32'd81);
        chk({nm, " grant acc"}, 32'(bus.grant_o), 32'(1 << r));
        fr = r;
        t_acc = c;
        k++;
      end
      @(posedge clk);
      #1;
      if (acc) void'(q[fr].pop_front());
      if (k == exp_q.size() && c >= t_acc + 81) break;
    end
    chk({nm, " accepts"}, 32'(k), 32'(exp_q.size()));
    drive();
    @(negedge clk);
    chk({nm, " grant idle"}, 32'(bus.grant_o), 32'd0);
    chk({nm, " tx idle"}, 32'(bus.tx_o), 32'd1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    q[0].push_back(8'h11);
    q[1].push_back(8'h22);
    drive();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst tx", 32'(bus.tx_o), 32'd1);
      chk("rst ready", 32'(bus.req_ready_o), 32'd0);
      chk("rst grant", 32'(bus.grant_o), 32'd0);
      chk("rst busy", 32'(bus.busy_o), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    run("reset_first");
    q[0] = '{8'h41, 8'h42, 8'h0A};
    q[1] = '{8'h55, 8'h0A};
    run("line_lock");
    q[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    q[1] = '{8'h0A};
    run("max_burst");
    q[0] = '{8'hA5};
    run("single");
    q[0] = '{8'h0A, 8'h0A};
    q[1] = '{8'h0A, 8'h0A};
    run("rr_newline");
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < NumReq; i++)
        repeat ($urandom_range(1, 4)) q[i].push_back($urandom_range(0, 3) == 0 ? 8'h0A : 8'($urandom));
      run($sformatf("rand%0d", s));
    end
    q[0] = '{8'hC3};
    drive();
    @(negedge clk);
    chk("mid ready", 32'(bus.req_ready_o), 32'd1);
    @(posedge clk);
    #1;
    void'(q[0].pop_front());
    drive();
    repeat (29) begin
      @(posedge clk);
      #1;
    end
    rst_ni = 1'b0;
    @(negedge clk);
    chk("mid tx T+30", 32'(bus.tx_o), 32'(exp_tx(8'hC3, 30)));
    chk("mid busy T+30", 32'(bus.busy_o), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid tx T+31", 32'(bus.tx_o), 32'd1);
    chk("mid busy T+31", 32'(bus.busy_o), 32'd0);
    chk("mid grant T+31", 32'(bus.grant_o), 32'd0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    m_last = NumReq - 1;
    m_lock = 1'b0;
    q[0] = '{8'h5A};
    q[1] = '{8'h6B};
    run("post_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
